// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-side types and constants for the instruction memory path.
package riscv_fetch_pkg;

    localparam int INSTR_W     = 32;
    localparam int IMEM_ADDR_W = 8;

    // Canonical RISC-V NOP (addi x0, x0, 0), reserved for the fetch stage.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // One instruction-fetch response as it travels through pipeline and FIFO.
    typedef struct packed {
        logic [INSTR_W-1:0]     instr;
        logic [IMEM_ADDR_W-1:0] addr;
        logic                   err;
    } resp_t;

    localparam int RESP_W = $bits(resp_t);

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO with a single-cycle clear. The head entry is
// presented combinationally and reads as zero while the FIFO is empty.
module resp_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             not_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    // Entry storage; validity is tracked by the pointers alone.
    // NOTE: the storage array has no reset so it can map onto RAM/LUTRAM;
    // stale contents are never visible because count gates the output.
    always_ff @(posedge clk) begin
        if (wr_en && !clear) store[wr_ptr] <= wr_data;
    end

    assign not_empty = (count != '0);
    assign rd_data   = not_empty ? store[rd_ptr] : '0;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: program-loadable word memory, a fixed-latency
// read pipeline and a response FIFO, with flush for taken branches.
module instr_mem_responder
    import riscv_fetch_pkg::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int DATA_W     = INSTR_W,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_W-1:0]               req_addr,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_W-1:0]               rsp_instr,
    output logic [ADDR_W-1:0]               rsp_addr,
    output logic                            rsp_err,
    input  logic                            flush,
    input  logic                            prog_we,
    input  logic [ADDR_W-1:0]               prog_addr,
    input  logic [DATA_W-1:0]               prog_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] outstanding
);

    localparam int OUT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];

    resp_t              pipe_data [LATENCY];
    logic [LATENCY-1:0] pipe_vld;

    logic  accept;
    logic  pop;
    logic  addr_err;
    resp_t fifo_out;
    logic  fifo_not_empty;

    // Outstanding counts pipeline plus FIFO, so the FIFO can never overflow.
    assign req_ready = !prog_we && (outstanding < OUT_W'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;
    // A pop in the flush cycle is moot: the entry is discarded anyway.
    assign pop       = fifo_not_empty && rsp_ready && !flush;
    assign addr_err  = int'(req_addr) >= DEPTH;

    // Program-load port; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (prog_we && (int'(prog_addr) < DEPTH)) mem[prog_addr] <= prog_data;
    end

    // Read data and metadata ride down the pipeline; the memory is sampled at
    // the accept edge, so later program writes never affect in-flight reads.
    always_ff @(posedge clk) begin
        pipe_data[0] <= '{instr: addr_err ? '0 : mem[req_addr],
                          addr:  req_addr,
                          err:   addr_err};
        for (int i = 1; i < LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
    end

    // Stage valid bits; flush kills everything older than a same-cycle accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= accept;
            for (int i = 1; i < LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1] && !flush;
        end
    end

    // In-flight plus buffered count; after a flush only the branch target remains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (flush) begin
            outstanding <= OUT_W'(accept);
        end else begin
            outstanding <= outstanding + OUT_W'(accept) - OUT_W'(pop);
        end
    end

    resp_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .wr_en     (pipe_vld[LATENCY-1]),
        .wr_data   (pipe_data[LATENCY-1]),
        .rd_en     (pop),
        .rd_data   (fifo_out),
        .not_empty (fifo_not_empty)
    );

    assign rsp_valid = fifo_not_empty;
    assign rsp_instr = fifo_out.instr;
    assign rsp_addr  = fifo_out.addr;
    assign rsp_err   = fifo_out.err;

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Responder side of the instruction-fetch interface: accepts 8-bit instruction addresses from the PC/fetch stage and returns 32-bit instruction words in order.
- Pipelined synchronous ROM/RAM with a response FIFO, valid/ready on both sides, and a flush for taken branches.
- A program-load write port fills the memory before or between runs.

Parameters:
- ADDR_W, 8, instruction address width (one word per address).
- DATA_W, 32, instruction word width.
- DEPTH, 256, implemented words; legal range 1..2**ADDR_W.
- LATENCY, 2, cycles from request acceptance to earliest rsp_valid; legal range 1..3.
- FIFO_DEPTH, 4, response FIFO entries and maximum outstanding requests; must be >= LATENCY+1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  ADDR_W  word address
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_instr  out  DATA_W  instruction word
- rsp_addr  out  ADDR_W  address that produced rsp_instr
- rsp_err  out  1  address >= DEPTH; rsp_instr forced to 0
- flush  in  1  discard all in-flight and buffered responses
- prog_we  in  1  program-load write strobe
- prog_addr  in  ADDR_W  load address
- prog_data  in  DATA_W  load data
- outstanding  out  $clog2(FIFO_DEPTH+1)  in-flight plus buffered count

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - rsp_valid=0, req_ready=1, outstanding=0.
  - rsp_instr, rsp_addr and rsp_err are all 0.
  - Pipeline and FIFO are empty.
  - Memory contents are not affected by rst.
- Reset mid-operation drops every in-flight and buffered response; no response for any pre-reset request ever appears.
- Acceptance rule:
  - req_ready = !prog_we && (outstanding < FIFO_DEPTH). It depends on current-cycle prog_we; there is no other combinational path from req_valid.
  - Accepted requests are always answered unless flushed or reset.
- Latency:
  - A request accepted at edge E produces rsp_valid no earlier than edge E+LATENCY.
  - It produces rsp_valid exactly at E+LATENCY if the FIFO is empty and not backpressured.
  - Sustained throughput is 1 response per cycle while rsp_ready=1.
- Ordering: responses are strictly in request order; no reordering, no drops, no duplicates.
- Response handshake:
  - rsp_* hold stable while rsp_valid && !rsp_ready.
  - A response pops on rsp_valid && rsp_ready.
- outstanding:
  - Increments on accept and decrements on pop; both together leaves it unchanged.
  - It never exceeds FIFO_DEPTH, so the FIFO cannot overflow.
- flush:
  - At the edge with flush=1, all pipeline entries and FIFO entries are invalidated and rsp_valid is 0 the next cycle.
  - A request accepted in the same cycle as flush is kept: it is the branch target.
  - After that edge, outstanding = 1 if a request was accepted that cycle, else 0.
  - A pop coincident with flush is ignored (the entry is discarded anyway).
- Errors:
  - req_addr >= DEPTH is still accepted.
  - Its response returns rsp_err=1, rsp_instr=0 and the offending rsp_addr.
  - It occupies one slot like any other response.
- Program load:
  - When prog_we=1, mem[prog_addr] <= prog_data at the edge; writes with prog_addr >= DEPTH are ignored.
  - Requests are blocked in the same cycle as a write.
  - Reads already in flight return the data from before the write.
- Control FSM states: RUN (normal operation) and FLUSH_ONLY, a transient one-cycle marker. Implementations may collapse this into per-entry valid bits, provided the timing above holds.
- Wrap-around: addresses are plain indices, with no modular behaviour beyond ADDR_W.

Decomposition:
- Shared package (riscv_fetch_pkg):
  - Constants INSTR_W=32 and IMEM_ADDR_W=8.
  - Constant NOP_INSTR=32'h00000013, for future use by the fetch stage.
  - Response struct {instr, addr, err}.
- One natural sub-module, resp_fifo: a synchronous FIFO of FIFO_DEPTH entries with a clear input, used for the response buffer.
- Memory array and latency pipeline stay in the top-level block.

Test Plan:
- Back-to-back, LATENCY=2, after loading mem[i]=32'h1000_0000+i:
  - Stimulus: addresses 0,1,2,3 on consecutive cycles with rsp_ready=1.
  - Required: rsp_valid from the 2nd edge after the first accept; rsp_instr 32'h10000000..32'h10000003 on consecutive cycles.
- Backpressure:
  - Stimulus: rsp_ready=0 while requesting addresses 0..5.
  - Required: exactly 4 accepted; req_ready=0 after that; outstanding=4; the 0x10000000 response holds stable.
  - Then set rsp_ready=1: responses drain in order 0..3, and address 4 is accepted the cycle after the first pop.
- Flush:
  - Stimulus: accept addresses 8,9,10, then flush=1 with req_addr=0x40 accepted in the same cycle.
  - Required: only the 0x40 response appears, 2 cycles later; outstanding=1 after the flush edge.
- Error:
  - Stimulus: DEPTH=200 variant, request address 250.
  - Required: rsp_err=1, rsp_instr=0, rsp_addr=250.
- Program load:
  - Stimulus: write mem[5]=32'hDEADBEEF with prog_we.
  - Required: req_ready=0 during the write cycle; a later read of address 5 returns 32'hDEADBEEF.
- Reset mid-operation:
  - Stimulus: assert rst with 3 outstanding requests.
  - Required: rsp_valid=0 and outstanding=0 immediately and asynchronously; after release, no stale responses appear, and memory still holds the loaded program.
